io_out_serializer: RTL and testbench
====================================

Name: io_out_serializer

Overview:
- Device-side endpoint of the bit16 processor's 16-bit I/O port.
- Captures words the processor writes on io_out into a FIFO and transmits them on a single-wire asynchronous serial line, LSB first.
- Drives a status word back onto the processor's io_in, so firmware can poll occupancy and errors.
- Sits between the bit16 core and the board-level serial pin.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of two, 2..128.
- CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- io_out  input  16  data word from the processor.
- io_we  input  1  write strobe; io_out is sampled on any rising edge where io_we=1.
- io_in  output  16  status word returned to the processor.
- tx  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is in progress (any state other than IDLE).
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at an edge): FIFO emptied, FSM returns to IDLE, tx=1, busy=0, overflow=0, io_in=16'h2000 (empty=1). Reset mid-frame aborts the frame; tx is high from the following cycle.
- FIFO:
  - Circular buffer with read/write pointers and count; count range 0..DEPTH.
  - A write is accepted when count<DEPTH, or when a pop happens in the same cycle (count unchanged).
  - When full with no pop, the write is dropped, the FIFO is unchanged and overflow sets. overflow stays set until rst.
  - A pop from an empty FIFO never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count>0, pop the head word into a 16-bit shift register, clear the bit counter and baud counter, go to START. Otherwise stay; tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After 16 bits, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame timing:
  - Frame = 18*CLKS_PER_BIT cycles.
  - A new frame may start on the cycle immediately after STOP ends (1 IDLE cycle between frames).
  - Back-to-back frames are therefore separated by exactly one extra idle cycle.
- Latency: io_we sampled at edge E0 (FIFO empty, IDLE):
  - word visible in FIFO after E0;
  - pop and START entry at E1;
  - tx low from E1 onward.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs on the wrap.
- io_in (combinational from registers):
  - [15] overflow
  - [14] full
  - [13] empty
  - [12] busy
  - [11:8] 0
  - [7:0] count, zero-extended
- Simultaneous io_we and pop at count=0 cannot occur: a pop requires count>0. The new word waits for the next IDLE cycle.

Optional Feature:
- Macro: IO_SER_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx carries the even parity of the 16 data bits (XOR of the word) for CLKS_PER_BIT cycles. Frame = 19*CLKS_PER_BIT cycles.
- Undefined: no PARITY state; frame = 18*CLKS_PER_BIT cycles.
- Status and FIFO behaviour are identical in both builds.

Test Plan (CLKS_PER_BIT=4, DEPTH=8, parity off unless stated):
- Single word: rst then release, write 16'h1234 once. Required:
  - tx low for 4 cycles starting at E1;
  - then bits 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0, 4 cycles each;
  - then high 4 cycles;
  - busy high for 72 cycles;
  - io_in returns to 16'h2000.
- Back-to-back: write 16'hA5A5 and 16'h0001 on consecutive cycles. Required:
  - io_in[7:0]=1 after the first pop;
  - second START begins exactly 73 cycles after the first;
  - decoded words match, in order.
- Overflow: hold tx busy and write 9 words 16'h0000..16'h0008 while the first frame runs. Required:
  - count reaches 8 with full=1;
  - one further write to the full FIFO is dropped;
  - io_in[15]=1 and overflow=1;
  - the dropped word is never transmitted.
- Full + pop same cycle: FIFO full, FSM entering IDLE, assert io_we with 16'hBEEF on the pop cycle. Required: count stays 8, overflow stays 0, 16'hBEEF is transmitted last.
- Reset mid-frame: assert rst during DATA bit 7. Required:
  - tx=1 from the next cycle;
  - busy=0, io_in=16'h2000;
  - no further frames, even though the FIFO held words before reset.
- Parity build (IO_SER_PARITY_EN defined): write 16'h0007. Required: parity bit = 1 for 4 cycles after data bit 15, then stop bit; frame length 76 cycles.

Source files
------------

// File: rtl/io_out_serializer.sv
// Serial output endpoint for the bit16 I/O port: FIFO-buffered words sent LSB first on tx.
// Define IO_SER_PARITY_EN to append an even-parity bit after the 16 data bits.
module io_out_serializer #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] io_out,
  input  logic        io_we,
  output logic [15:0] io_in,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef IO_SER_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   shift;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud;
`ifdef IO_SER_PARITY_EN
  logic          parity_bit;
`endif

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic baud_wrap;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // A full FIFO still accepts a write when the FSM pops in the same cycle.
  assign pop       = (state == IDLE) && !empty;
  assign push      = io_we && (!full || pop);
  assign baud_wrap = (baud == BW'(CLKS_PER_BIT - 1));

  assign busy  = (state != IDLE);
  assign io_in = {overflow, full, empty, busy, 4'b0000, 8'(count)};

  // NOTE: storage has no reset; entries are only read after being written, so
  // leaving them out of reset keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io_out;
  end

  // NOTE: every sequential block uses non-blocking assignments so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (io_we && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
      baud    <= '0;
`ifdef IO_SER_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= '0;
            baud    <= '0;
            tx      <= 1'b0;
            state   <= START;
`ifdef IO_SER_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
          end
        end
        START: begin
          if (baud_wrap) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud <= '0;
            if (bit_cnt == 4'd15) begin
`ifdef IO_SER_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef IO_SER_PARITY_EN
        PARITY: begin
          if (baud_wrap) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_wrap) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_out_serializer.sv
// Scoreboard bench for io_out_serializer: writes push expected words, a serial
// monitor decodes tx frames and compares them in order.
module tb_io_out_serializer;

  localparam int DEPTH = 8;
  localparam int CPB   = 4;
`ifdef IO_SER_PARITY_EN
  localparam int FRAME_CYC = 19 * CPB;
`else
  localparam int FRAME_CYC = 18 * CPB;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] io_out = '0;
  logic        io_we = 1'b0;
  logic [15:0] io_in;
  logic        tx;
  logic        busy;
  logic        overflow;

  io_out_serializer #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_out   (io_out),
    .io_we    (io_we),
    .io_in    (io_in),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  logic [15:0] exp_q[$];
  int          starts[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] w, input bit expect_tx);
    io_we  = 1'b1;
    io_out = w;
    if (expect_tx) exp_q.push_back(w);
    tick();
    io_we = 1'b0;
  endtask

  // Serial monitor: decodes frames on tx, sampling on the falling clock edge.
  int          mon_st  = 0;
  int          mon_cyc = 0;
  int          mon_bit = 0;
  logic [15:0] mon_word;
  logic        mon_par;
  bit          mon_ok;

  task automatic finish_frame();
    logic [15:0] w;
    check("frame_expected", 32'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("frame_word", mon_word, w);
      check("frame_shape", mon_ok, 1);
`ifdef IO_SER_PARITY_EN
      check("frame_parity", mon_par, ^w);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_st = 0;
    end else begin
      case (mon_st)
        0: if (tx === 1'b0) begin
          starts.push_back(cyc_cnt);
          mon_st   = 1;
          mon_cyc  = 1;
          mon_ok   = 1'b1;
          mon_word = '0;
        end
        1: begin
          if (tx !== 1'b0) mon_ok = 1'b0;
          mon_cyc++;
          if (mon_cyc == CPB) begin
            mon_st  = 2;
            mon_cyc = 0;
            mon_bit = 0;
          end
        end
        2: begin
          if (mon_cyc == 0) mon_word[mon_bit] = tx;
          else if (tx !== mon_word[mon_bit]) mon_ok = 1'b0;
          mon_cyc++;
          if (mon_cyc == CPB) begin
            mon_cyc = 0;
            mon_bit++;
`ifdef IO_SER_PARITY_EN
            if (mon_bit == 16) mon_st = 3;
`else
            if (mon_bit == 16) mon_st = 4;
`endif
          end
        end
        3: begin
          if (mon_cyc == 0) mon_par = tx;
          else if (tx !== mon_par) mon_ok = 1'b0;
          mon_cyc++;
          if (mon_cyc == CPB) begin
            mon_cyc = 0;
            mon_st  = 4;
          end
        end
        4: begin
          if (tx !== 1'b1) mon_ok = 1'b0;
          mon_cyc++;
          if (mon_cyc == CPB) begin
            finish_frame();
            mon_st = 0;
          end
        end
        default: mon_st = 0;
      endcase
    end
  end

  task automatic drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && mon_st == 0) break;
      tick();
    end
    check("drain_done", exp_q.size(), 0);
    repeat (2 * FRAME_CYC) tick();
  endtask

  initial begin
    int n;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_io_in", io_in, 16'h2000);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    // Single word: frame length measured from busy.
    starts.delete();
    write_word(16'h1234, 1'b1);
    check("t1_queued", io_in, 16'h0001);
    tick();
    check("t1_tx_start", tx, 0);
    check("t1_io_in_busy", io_in, 16'h3000);
    n = 1;
    for (int i = 0; i < 200 && busy; i++) begin
      tick();
      if (busy) n++;
    end
    check("t1_busy_len", n, FRAME_CYC);
    check("t1_io_in_idle", io_in, 16'h2000);
    drain(200);
    check("t1_one_frame", starts.size(), 1);

    // Back-to-back writes.
    starts.delete();
    write_word(16'hA5A5, 1'b1);
    write_word(16'h0001, 1'b1);
    check("t2_count_after_pop", io_in, 16'h1001);
    drain(400);
    check("t2_frames", starts.size(), 2);
    if (starts.size() >= 2) check("t2_start_gap", starts[1] - starts[0], FRAME_CYC + 1);

    // Overflow: ninth buffered write fills FIFO, the next one is dropped.
    for (int i = 0; i < 9; i++) write_word(16'(i), 1'b1);
    check("t3_full", io_in, 16'h5008);
    check("t3_no_ovf_yet", overflow, 0);
    write_word(16'hDEAD, 1'b0);
    check("t3_ovf_status", io_in, 16'hD008);
    check("t3_ovf_flag", overflow, 1);
    drain(1200);
    check("t3_ovf_sticky", io_in, 16'hA000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t3_rst_clears", io_in, 16'h2000);

    // Full FIFO with write on the pop cycle.
    for (int i = 0; i < 9; i++) write_word(16'h0100 + 16'(i), 1'b1);
    check("t4_full", io_in, 16'h5008);
    for (int i = 0; i < 200 && busy; i++) tick();
    check("t4_reached_idle", busy, 0);
    write_word(16'hBEEF, 1'b1);
    check("t4_count_kept", io_in, 16'h5008);
    check("t4_no_ovf", overflow, 0);
    drain(1200);

    // Reset during data bit 7 aborts the frame and flushes the FIFO.
    write_word(16'h1111, 1'b1);
    write_word(16'h2222, 1'b1);
    repeat (34) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_tx_high", tx, 1);
    check("t5_busy_low", busy, 0);
    check("t5_io_in", io_in, 16'h2000);
    exp_q.delete();
    starts.delete();
    repeat (200) tick();
    check("t5_no_frames", starts.size(), 0);
    check("t5_tx_idle", tx, 1);

`ifdef IO_SER_PARITY_EN
    // Parity build: odd-weight word gives parity bit 1.
    starts.delete();
    write_word(16'h0007, 1'b1);
    tick();
    n = 1;
    for (int i = 0; i < 200 && busy; i++) begin
      tick();
      if (busy) n++;
    end
    check("t6_busy_len", n, 76);
    drain(200);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
